// File: rtl/sgpr_wr_arbiter_pkg.sv
// sgpr_wr_pkg: shared types and constants for the scalar register-file write
// arbiter.
//   state_t      write-port FSM states (LO/HI exist only for split 64-bit writes)
//   SGPR_ADDR_W  default SGPR write address width
//   SGPR_DATA_W  default SGPR write data width
//   pair_base()  even base address of a 64-bit register pair
package sgpr_wr_pkg;

    typedef enum logic [1:0] {IDLE, ONE, LO, HI} state_t;

    localparam int SGPR_ADDR_W = 8;
    localparam int SGPR_DATA_W = 64;

    // 64-bit pairs always start on an even SGPR; clear bit 0 of the address.
    function automatic logic [31:0] pair_base(input logic [31:0] addr);
        return {addr[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/sgpr_wr_arbiter_if.sv
// sgpr_wr_arbiter_if: bundle of NUM_REQ write requesters, packed per requester.
//   req_valid/req_ready  per-requester handshake (ready is a one-hot grant)
//   req_addr             requester i at [i*ADDR_W +: ADDR_W]
//   req_data             requester i at [i*DATA_W +: DATA_W]
//   req_is64             1 = 64-bit pair write
//   req_scc_we/req_scc   optional SCC update carried with the write
// master = requester side, slave = arbiter side.
interface sgpr_wr_arbiter_if
    import sgpr_wr_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = SGPR_ADDR_W,
    parameter int DATA_W  = SGPR_DATA_W
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_is64;
    logic [NUM_REQ-1:0]        req_scc_we;
    logic [NUM_REQ-1:0]        req_scc;

    modport master (
        output req_valid, req_addr, req_data, req_is64, req_scc_we, req_scc,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_is64, req_scc_we, req_scc,
        output req_ready
    );
endinterface

// File: rtl/sgpr_wr_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req     request vector
//   ptr     highest-priority index this cycle (search wraps modulo NUM_REQ)
//   enable  0 forces gnt to zero
//   gnt     one-hot grant, or zero
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] gnt
);
    logic found;
    int   idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (enable && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sgpr_wr_arbiter.sv
// sgpr_wr_arbiter: shares the scalar regFile write port between NUM_REQ
// producers with round-robin arbitration and a registered write port.
//   clock, reset   rising-edge clock, synchronous active-high reset
//   req            requester bundle (slave side)
//   w0/wv          regFile write select / value
//   en_w/en_64     write enable / 64-bit pair write
//   SCC_in/scc_we  SCC value and write strobe
//   err_misalign   1-cycle pulse: 64-bit request with odd address
// Build option SGPR_WR_SPLIT64_EN: 64-bit writes go out as two 32-bit beats
// (LO at the pair base, HI at base|1) and en_64 is never asserted.
module sgpr_wr_arbiter
    import sgpr_wr_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = SGPR_ADDR_W,
    parameter int DATA_W  = SGPR_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    sgpr_wr_arbiter_if.slave  req,
    output logic [ADDR_W-1:0] w0,
    output logic [DATA_W-1:0] wv,
    output logic              en_w,
    output logic              en_64,
    output logic              SCC_in,
    output logic              scc_we,
    output logic              err_misalign
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   ptr;
    logic [NUM_REQ-1:0] gnt;
    logic               can_accept, accept, split_beat;

    logic [PTR_W-1:0]   sel;
    logic [ADDR_W-1:0]  sel_addr, sel_base;
    logic [DATA_W-1:0]  sel_data, sel_lo32;
    logic               sel_is64, sel_scc_we, sel_scc;

`ifdef SGPR_WR_SPLIT64_EN
    logic [ADDR_W-1:0]  hi_addr;
    logic [31:0]        hi_data;
    logic               hi_scc_we, hi_scc;
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
        .req    (req.req_valid),
        .ptr    (ptr),
        .enable (can_accept),
        .gnt    (gnt)
    );

    // Mux the granted requester's fields.
    always_comb begin
        sel        = '0;
        sel_addr   = '0;
        sel_data   = '0;
        sel_is64   = 1'b0;
        sel_scc_we = 1'b0;
        sel_scc    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel        = PTR_W'(i);
                sel_addr   = req.req_addr[i*ADDR_W +: ADDR_W];
                sel_data   = req.req_data[i*DATA_W +: DATA_W];
                sel_is64   = req.req_is64[i];
                sel_scc_we = req.req_scc_we[i];
                sel_scc    = req.req_scc[i];
            end
        end
    end

    assign accept   = |gnt;
    assign sel_base = sel_is64 ? ADDR_W'(pair_base(32'(sel_addr))) : sel_addr;
    assign sel_lo32 = {{(DATA_W-32){1'b0}}, sel_data[31:0]};
`ifdef SGPR_WR_SPLIT64_EN
    assign split_beat = sel_is64;
`else
    assign split_beat = 1'b0;
`endif

    // FSM: state register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = IDLE;
        if (accept)            state_nxt = split_beat ? LO : ONE;
        else if (state == LO)  state_nxt = HI;
    end

    // FSM: outputs. The LO cycle blocks grants so the HI beat owns the next
    // cycle and the write port stays continuously busy.
    always_comb begin
        can_accept    = !reset && (state != LO);
        req.req_ready = gnt;
    end

    // Pointer and registered write port.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr          <= '0;
            w0           <= '0;
            wv           <= '0;
            en_w         <= 1'b0;
            en_64        <= 1'b0;
            SCC_in       <= 1'b0;
            scc_we       <= 1'b0;
            err_misalign <= 1'b0;
`ifdef SGPR_WR_SPLIT64_EN
            hi_addr      <= '0;
            hi_data      <= '0;
            hi_scc_we    <= 1'b0;
            hi_scc       <= 1'b0;
`endif
        end else begin
            en_w         <= 1'b0;
            en_64        <= 1'b0;
            scc_we       <= 1'b0;
            err_misalign <= 1'b0;
            if (accept) begin
                ptr          <= (sel == PTR_W'(NUM_REQ-1)) ? '0 : sel + 1'b1;
                en_w         <= 1'b1;
                w0           <= sel_base;
                err_misalign <= sel_is64 & sel_addr[0];
                if (split_beat) begin
                    // LO beat now; SCC waits for the HI (final) beat.
                    wv     <= sel_lo32;
                    SCC_in <= 1'b0;
`ifdef SGPR_WR_SPLIT64_EN
                    hi_addr   <= sel_base | ADDR_W'(1);
                    hi_data   <= sel_data[63:32];
                    hi_scc_we <= sel_scc_we;
                    hi_scc    <= sel_scc;
`endif
                end else begin
                    wv     <= sel_is64 ? sel_data : sel_lo32;
                    en_64  <= sel_is64;
                    scc_we <= sel_scc_we;
                    SCC_in <= sel_scc;
                end
            end
`ifdef SGPR_WR_SPLIT64_EN
            else if (state == LO) begin
                en_w   <= 1'b1;
                w0     <= hi_addr;
                wv     <= {{(DATA_W-32){1'b0}}, hi_data};
                scc_we <= hi_scc_we;
                SCC_in <= hi_scc;
            end
`endif
        end
    end
endmodule

// File: tb/tb_sgpr_wr_arbiter.sv
module tb_sgpr_wr_arbiter;
    import sgpr_wr_pkg::*;

    localparam int N = 3;
`ifdef SGPR_WR_SPLIT64_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  w0;
    logic [63:0] wv;
    logic        en_w, en_64, SCC_in, scc_we, err_misalign;

    sgpr_wr_arbiter_if #(.NUM_REQ(N), .ADDR_W(8), .DATA_W(64)) bus();

    sgpr_wr_arbiter #(.NUM_REQ(N), .ADDR_W(8), .DATA_W(64)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (bus),
        .w0           (w0),
        .wv           (wv),
        .en_w         (en_w),
        .en_64        (en_64),
        .SCC_in       (SCC_in),
        .scc_we       (scc_we),
        .err_misalign (err_misalign)
    );

    always #5 clock = ~clock;

    // Per-requester stimulus, packed onto the bus.
    logic [N-1:0] v, is64, sccwe, scc;
    logic [7:0]   addr [N];
    logic [63:0]  data [N];

    always_comb begin
        bus.req_valid  = v;
        bus.req_is64   = is64;
        bus.req_scc_we = sccwe;
        bus.req_scc    = scc;
        bus.req_addr   = '0;
        bus.req_data   = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*8 +: 8]   = addr[i];
            bus.req_data[i*64 +: 64] = data[i];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: a queue of write beats the port owes, one per cycle.
    typedef struct {
        logic [7:0]  a;
        logic [63:0] d;
        logic        e64, swe, sc, err, lo;
    } beat_t;

    beat_t       q[$];
    int          mptr = 0;
    logic        cur_lo = 1'b0;
    logic [7:0]  last_w0 = '0;
    logic [63:0] last_wv = '0;

    // Inputs are already settled; check grant, advance one clock, check port.
    task automatic tick();
        int          g, idx;
        logic [N-1:0] eg;
        logic [7:0]  base;
        beat_t       b;
        g = -1;
        if (!reset && !cur_lo) begin
            for (int k = 0; k < N; k++) begin
                idx = (mptr + k) % N;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        chk("req_ready", bus.req_ready, eg);
        if (g >= 0) begin
            mptr = (g + 1) % N;
            base = is64[g] ? {addr[g][7:1], 1'b0} : addr[g];
            if (SPLIT && is64[g]) begin
                q.push_back('{base, {32'b0, data[g][31:0]}, 1'b0, 1'b0, 1'b0, addr[g][0], 1'b1});
                q.push_back('{base | 8'h01, {32'b0, data[g][63:32]}, 1'b0, sccwe[g], scc[g], 1'b0, 1'b0});
            end else begin
                q.push_back('{base, is64[g] ? data[g] : {32'b0, data[g][31:0]},
                              is64[g], sccwe[g], scc[g], is64[g] & addr[g][0], 1'b0});
            end
        end
        @(posedge clock);
        #1;
        if (reset) begin
            q.delete();
            mptr = 0; cur_lo = 1'b0; last_w0 = '0; last_wv = '0;
            chk("rst_en_w", en_w, 0);
            chk("rst_w0", w0, 0);
            chk("rst_wv", wv, 0);
            chk("rst_en_64", en_64, 0);
            chk("rst_scc", {scc_we, SCC_in}, 0);
            chk("rst_err", err_misalign, 0);
        end else if (q.size() > 0) begin
            b = q.pop_front();
            cur_lo = b.lo; last_w0 = b.a; last_wv = b.d;
            chk("en_w", en_w, 1);
            chk("w0", w0, b.a);
            chk("wv", wv, b.d);
            chk("en_64", en_64, b.e64);
            chk("scc_we", scc_we, b.swe);
            if (b.swe) chk("SCC_in", SCC_in, b.sc);
            chk("err_misalign", err_misalign, b.err);
        end else begin
            cur_lo = 1'b0;
            chk("idle_en_w", en_w, 0);
            chk("idle_scc_we", scc_we, 0);
            chk("idle_err", err_misalign, 0);
            chk("idle_w0_hold", w0, last_w0);
            chk("idle_wv_hold", wv, last_wv);
        end
    endtask

    typedef struct {
        logic [2:0] v, s64;
        logic [7:0] a0;
        logic [2:0] rdy;
        logic [7:0] w;
        logic       chkw;
        logic       err;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{3'b111, 3'b000, 8'h04, 3'b001, 8'h04, 1'b1, 1'b0};
        tbl[1] = '{3'b111, 3'b000, 8'h04, 3'b010, 8'h05, 1'b1, 1'b0};
        tbl[2] = '{3'b111, 3'b000, 8'h04, 3'b100, 8'h06, 1'b1, 1'b0};
        tbl[3] = '{3'b111, 3'b000, 8'h04, 3'b001, 8'h04, 1'b1, 1'b0};
        tbl[4] = '{3'b001, 3'b001, 8'h07, 3'b001, 8'h06, 1'b1, 1'b1};
        tbl[5] = '{3'b000, 3'b000, 8'h04, 3'b000, 8'h00, 1'b0, 1'b0};
        tbl[6] = '{3'b000, 3'b000, 8'h04, 3'b000, 8'h00, 1'b0, 1'b0};

        v = '1; is64 = '0; sccwe = '0; scc = '0;
        addr[0] = 8'h04; addr[1] = 8'h05; addr[2] = 8'h06;
        for (int i = 0; i < N; i++) data[i] = {$urandom, $urandom};

        // Reset for two cycles with everyone requesting.
        #1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("first_grant", bus.req_ready, 3'b001);

        // Round robin and the misaligned 64-bit case.
        for (int r = 0; r < 7; r++) begin
            v = tbl[r].v; is64 = tbl[r].s64; addr[0] = tbl[r].a0;
            #1;
            chk("tbl_ready", bus.req_ready, tbl[r].rdy);
            tick();
            if (tbl[r].chkw) chk("tbl_w0", w0, tbl[r].w);
            chk("tbl_err", err_misalign, tbl[r].err);
        end

        // 64-bit write with SCC update from requester 1.
        v = 3'b010; is64 = 3'b010; addr[1] = 8'h0A; data[1] = 64'hDEAD_BEEF_1234_5678;
        sccwe = 3'b010; scc = 3'b010;
        #1;
        tick();
        if (SPLIT) begin
            chk("lo_w0", w0, 8'h0A);
            chk("lo_wv", wv, 64'h1234_5678);
            chk("lo_scc_we", scc_we, 0);
            #1;
            chk("lo_ready_blocked", bus.req_ready, 3'b000);
            v = 3'b000;
            tick();
            chk("hi_w0", w0, 8'h0B);
            chk("hi_wv", wv, 64'hDEAD_BEEF);
            chk("hi_scc", {scc_we, SCC_in}, 2'b11);
        end else begin
            chk("w64_en_64", en_64, 1);
            chk("w64_w0", w0, 8'h0A);
            chk("w64_wv", wv, 64'hDEAD_BEEF_1234_5678);
            chk("w64_scc", {scc_we, SCC_in}, 2'b11);
            v = 3'b000;
        end
        #1;
        tick();

        // Reset during the first beat of a 64-bit write drops the rest.
        v = 3'b001; is64 = 3'b001; addr[0] = 8'h10; sccwe = '0;
        #1;
        tick();
        reset = 1'b1; v = '1;
        #1;
        tick();
        reset = 1'b0; v = '0;
        #1;
        tick();
        chk("no_beat_after_rst", en_w, 0);
        v = '1;
        #1;
        chk("ptr_after_rst", bus.req_ready, 3'b001);
        tick();

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            v = N'($urandom); is64 = N'($urandom); sccwe = N'($urandom); scc = N'($urandom);
            for (int i = 0; i < N; i++) begin
                addr[i] = 8'($urandom);
                data[i] = {$urandom, $urandom};
            end
            reset = ($urandom_range(0, 49) == 0);
            #1;
            tick();
        end
        reset = 1'b0; v = '0;
        #1;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
